// File: rtl/dec_scan_seq.sv
// Scan-code sequencer driving the 4-bit select of a 4-to-16 decoder, one code per dwell period.
// Optional feature: define DEC_SCAN_DIR_EN to add the dir port and selectable down-scan.
module dec_scan_seq #(
    parameter int unsigned DWELL = 50
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       stop,
    input  logic       mode,
`ifdef DEC_SCAN_DIR_EN
    input  logic       dir,
`endif
    output logic [3:0] sel,
    output logic       sel_valid,
    output logic       tick,
    output logic       busy,
    output logic       done
);

    localparam int unsigned   CntW   = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam logic [CntW-1:0] CntMax = CntW'(DWELL - 1);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e          state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [3:0]      sel_q, sel_d;
    logic            mode_q, mode_d;
    logic            valid_q, valid_d;
    logic            tick_q, tick_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic            down;
    logic [3:0]      first_code, last_code, next_code;

`ifdef DEC_SCAN_DIR_EN
    logic down_q, down_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            down_q <= 1'b0;
        end else begin
            down_q <= down_d;
        end
    end

    assign down = down_q;
`else
    assign down = 1'b0;
`endif

    // Up-scan runs 0..15, down-scan 15..0.
    assign first_code = {4{down}};
    assign last_code  = {4{~down}};
    assign next_code  = down ? (sel_q - 4'd1) : (sel_q + 4'd1);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sel_d   = sel_q;
        mode_d  = mode_q;
`ifdef DEC_SCAN_DIR_EN
        down_d  = down_q;
`endif
        case (state_q)
            StIdle: begin
                cnt_d = '0;
                if (start && !stop) begin
                    state_d = StRun;
                    mode_d  = mode;
`ifdef DEC_SCAN_DIR_EN
                    down_d  = dir;
                    sel_d   = {4{dir}};
`else
                    sel_d   = 4'h0;
`endif
                end
            end
            StRun: begin
                if (stop) begin
                    state_d = StIdle;
                    cnt_d   = '0;
                end else if (cnt_q == CntMax) begin
                    cnt_d = '0;
                    if (sel_q == last_code) begin
                        if (mode_q) begin
                            sel_d = first_code;
                        end else begin
                            state_d = StDone;
                        end
                    end else begin
                        sel_d = next_code;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
                cnt_d   = '0;
            end
        endcase

        // Outputs are registered from the next state so they line up with sel.
        valid_d = (state_d == StRun);
        busy_d  = (state_d != StIdle);
        done_d  = (state_d == StDone);
        tick_d  = (state_d == StRun) && (cnt_d == CntMax);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            sel_q   <= 4'h0;
            mode_q  <= 1'b0;
            valid_q <= 1'b0;
            tick_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sel_q   <= sel_d;
            mode_q  <= mode_d;
            valid_q <= valid_d;
            tick_q  <= tick_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign sel       = sel_q;
    assign sel_valid = valid_q;
    assign tick      = tick_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule
